// File: rtl/prog_mem_loader_pkg.sv
// Shared types and constants for the PicoBlaze program-memory loader.
// Frame: SYNC, LEN_HI, LEN_LO, N x (B0,B1,B2), CSUM.
package prog_mem_loader_pkg;

    localparam int ADDR_W = 10;
    localparam int INSTR_W = 18;
    localparam logic [7:0] SYNC_DEF = 8'h5A;
    localparam int TIMEOUT_DEF = 50000;

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, B0, B1, B2,
        WRITE, CSUM, DONE, ERR
    } state_t;

    function automatic logic [7:0] csum_add(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_mem_loader_timeout.sv
// Idle-gap counter: counts cycles without an accepted byte while enabled.
// expired fires on the edge at which the count reaches LIMIT-1.
module loader_timeout #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(LIMIT) + 1;

    logic [W-1:0] cnt;
    logic [W-1:0] nxt;

    always_comb begin
        nxt = cnt + W'(1);
        if (clr || !en) begin
            nxt = '0;
        end
    end

    assign expired = en && !clr && (nxt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Serial frame loader for the PicoBlaze program memory (block-RAM port A).
// Holds the CPU in reset while a frame is being written.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_data,
    output logic               mem_we,
    output logic               cpu_reset,
    output logic               load_busy,
    output logic               load_done,
    output logic               load_err
);

    state_t            state;
    logic [1:0]        len_hi;
    logic [ADDR_W-1:0] left_cnt;
    logic [9:0]        asm_q;
    logic [7:0]        sum;
    logic              acc;
    logic              tmo_en;
    logic              tmo_exp;

    assign acc = rx_valid & rx_ready;
    assign tmo_en = state inside {LEN_HI, LEN_LO, B0, B1, B2, WRITE, CSUM};

    loader_timeout #(
        .LIMIT(TIMEOUT_CYC)
    ) u_tmo (
        .clk(clk),
        .rst_n(rst_n),
        .en(tmo_en),
        .clr(acc),
        .expired(tmo_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_we    <= 1'b0;
            cpu_reset <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            len_hi    <= '0;
            left_cnt  <= '0;
            asm_q     <= '0;
            sum       <= '0;
        end else begin
            mem_we   <= 1'b0;
            rx_ready <= 1'b1;
            unique case (state)
                IDLE: if (acc && rx_data == SYNC_BYTE) begin
                    load_done <= 1'b0;
                    load_err  <= 1'b0;
                    cpu_reset <= 1'b1;
                    load_busy <= 1'b1;
                    sum       <= '0;
                    state     <= LEN_HI;
                end
                LEN_HI: if (acc) begin
                    sum    <= csum_add(sum, rx_data);
                    len_hi <= rx_data[1:0];
                    state  <= (rx_data[7:2] == 6'd0) ? LEN_LO : ERR;
                end
                LEN_LO: if (acc) begin
                    sum      <= csum_add(sum, rx_data);
                    left_cnt <= {len_hi, rx_data};
                    mem_addr <= '0;
                    state    <= B0;
                end
                B0: if (acc) begin
                    sum        <= csum_add(sum, rx_data);
                    asm_q[9:8] <= rx_data[1:0];
                    state      <= B1;
                end
                B1: if (acc) begin
                    sum        <= csum_add(sum, rx_data);
                    asm_q[7:0] <= rx_data;
                    state      <= B2;
                end
                B2: if (acc) begin
                    sum      <= csum_add(sum, rx_data);
                    mem_data <= {asm_q, rx_data};
                    mem_we   <= 1'b1;
                    rx_ready <= 1'b0;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (left_cnt == '0) begin
                        state <= CSUM;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        left_cnt <= left_cnt - ADDR_W'(1);
                        state    <= B0;
                    end
                end
                CSUM: if (acc) begin
                    state <= (csum_add(sum, rx_data) == 8'h00) ? DONE : ERR;
                end
                DONE: begin
                    load_done <= 1'b1;
                    cpu_reset <= 1'b0;
                    load_busy <= 1'b0;
                    state     <= IDLE;
                end
                ERR: begin
                    // cpu_reset stays high: memory holds a partial image
                    load_err  <= 1'b1;
                    load_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (tmo_exp) begin
                state <= ERR;
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomised frame bench for prog_mem_loader with a queue-based frame model.
module tb_prog_mem_loader;

    localparam int TMO = 16;
    localparam logic [7:0] SYNC = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [9:0]  mem_addr;
    logic [17:0] mem_data;
    logic        mem_we;
    logic        cpu_reset;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;

    logic [27:0] wr_q[$];
    logic [17:0] exp_words[$];
    logic [7:0]  frame_q[$];

    always #5 clk = ~clk;

    prog_mem_loader #(
        .TIMEOUT_CYC(TMO),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .cpu_reset(cpu_reset),
        .load_busy(load_busy),
        .load_done(load_done),
        .load_err(load_err)
    );

    // Memory-side observer: every write strobe and every busy stall cycle.
    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_data});
        if (load_busy && !rx_ready) stall_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte: rx_ready=%b want 1 (byte %h)",
                     rx_ready, b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Frame model: length field N-1, B0 upper bits random, 8-bit zero-sum.
    task automatic build_frame(input bit bad);
        logic [9:0]  lf;
        logic [17:0] w;
        logic [7:0]  s;
        logic [7:0]  b;
        logic [7:0]  cs;
        frame_q.delete();
        lf = 10'(exp_words.size() - 1);
        frame_q.push_back(SYNC);
        b = {6'd0, lf[9:8]};
        frame_q.push_back(b);
        frame_q.push_back(lf[7:0]);
        s = b + lf[7:0];
        foreach (exp_words[i]) begin
            w = exp_words[i];
            b = {6'($urandom), w[17:16]};
            frame_q.push_back(b);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
            s = s + b + w[15:8] + w[7:0];
        end
        cs = 8'(0) - s;
        if (bad) cs = cs + 8'($urandom_range(1, 255));
        frame_q.push_back(cs);
    endtask

    task automatic send_bytes(input int cnt, input int gap);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, gap)) @(posedge clk);
            send_byte(frame_q[i]);
        end
    endtask

    task automatic do_frame(input bit bad, input int gap);
        build_frame(bad);
        send_bytes(frame_q.size(), gap);
    endtask

    task automatic test_reset;
        logic [33:0] outs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outs = {rx_ready, mem_addr, mem_data, mem_we,
                cpu_reset, load_busy, load_done, load_err};
        checks++;
        if (outs !== 34'd0) begin
            failures++;
            $display("FAIL reset_vals: got %h want 0", outs);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL first_cycle_ready: got %b want 0", rx_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 1", rx_ready);
        end
    endtask

    task automatic test_idle_discard;
        int base;
        base = wr_q.size();
        send_byte(8'h00);
        send_byte(8'h11);
        @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != base) begin
            failures++;
            $display("FAIL idle_writes: got %0d want 0", wr_q.size() - base);
        end
        checks++;
        if ({cpu_reset, load_busy, load_done, load_err} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_flags: got %b want 0000",
                     {cpu_reset, load_busy, load_done, load_err});
        end
    endtask

    task automatic test_good_frame;
        int base;
        base = wr_q.size();
        exp_words.delete();
        exp_words.push_back(18'h34010);
        exp_words.push_back(18'h0CAFE);
        build_frame(1'b0);
        send_bytes(1, 0);
        checks++;
        if ({cpu_reset, load_busy} !== 2'b11) begin
            failures++;
            $display("FAIL sync_flags: got %b want 11",
                     {cpu_reset, load_busy});
        end
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i]);
        checks++;
        if ({cpu_reset, load_done} !== 2'b10) begin
            failures++;
            $display("FAIL done_latency: rst/done=%b want 10",
                     {cpu_reset, load_done});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cpu_reset, load_busy, load_done, load_err} !== 4'b0010) begin
            failures++;
            $display("FAIL good_end: rst/busy/done/err=%b want 0010",
                     {cpu_reset, load_busy, load_done, load_err});
        end
        checks++;
        if (wr_q.size() - base != 2) begin
            failures++;
            $display("FAIL good_count: got %0d want 2", wr_q.size() - base);
        end
        for (int i = 0; i < 2 && base + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[base+i] !== {10'(i), exp_words[i]}) begin
                failures++;
                $display("FAIL good_word%0d: got %h want %h",
                         i, wr_q[base+i], {10'(i), exp_words[i]});
            end
        end
    endtask

    task automatic test_bad_csum;
        int base;
        base = wr_q.size();
        do_frame(1'b1, 0);
        @(posedge clk);
        #1;
        checks++;
        if ({cpu_reset, load_busy, load_done, load_err} !== 4'b1001) begin
            failures++;
            $display("FAIL bad_csum: rst/busy/done/err=%b want 1001",
                     {cpu_reset, load_busy, load_done, load_err});
        end
        checks++;
        if (wr_q.size() - base != exp_words.size()) begin
            failures++;
            $display("FAIL bad_csum_count: got %0d want %0d",
                     wr_q.size() - base, exp_words.size());
        end
        do_frame(1'b0, 1);
        @(posedge clk);
        #1;
        checks++;
        if ({cpu_reset, load_done, load_err} !== 3'b010) begin
            failures++;
            $display("FAIL recover: rst/done/err=%b want 010",
                     {cpu_reset, load_done, load_err});
        end
    endtask

    task automatic test_bad_len;
        int base;
        base = wr_q.size();
        send_byte(SYNC);
        send_byte(8'h04);
        @(posedge clk);
        #1;
        checks++;
        if ({load_busy, load_done, load_err} !== 3'b001) begin
            failures++;
            $display("FAIL bad_len: busy/done/err=%b want 001",
                     {load_busy, load_done, load_err});
        end
        checks++;
        if (wr_q.size() != base) begin
            failures++;
            $display("FAIL bad_len_writes: got %0d want 0", wr_q.size() - base);
        end
    endtask

    task automatic test_timeout;
        int base;
        int first;
        base = wr_q.size();
        first = 0;
        exp_words.delete();
        exp_words.push_back(18'($urandom));
        build_frame(1'b0);
        send_bytes(5, 0);
        for (int i = 1; i <= TMO + 8; i++) begin
            @(posedge clk);
            #1;
            if (load_err && first == 0) first = i;
        end
        checks++;
        if (first != TMO) begin
            failures++;
            $display("FAIL timeout_cycle: got %0d want %0d", first, TMO);
        end
        checks++;
        if (wr_q.size() != base || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_state: writes=%0d busy=%b want 0 0",
                     wr_q.size() - base, load_busy);
        end
    endtask

    task automatic test_random_frames;
        int base;
        bit bad;
        repeat (6) begin
            exp_words.delete();
            repeat ($urandom_range(1, 12)) exp_words.push_back(18'($urandom));
            bad = ($urandom_range(0, 2) == 0);
            base = wr_q.size();
            do_frame(bad, 3);
            @(posedge clk);
            #1;
            checks++;
            if ({cpu_reset, load_done, load_err} !== {bad, !bad, bad}) begin
                failures++;
                $display("FAIL rand_flags: rst/done/err=%b want %b",
                         {cpu_reset, load_done, load_err}, {bad, !bad, bad});
            end
            checks++;
            if (wr_q.size() - base != exp_words.size()) begin
                failures++;
                $display("FAIL rand_count: got %0d want %0d",
                         wr_q.size() - base, exp_words.size());
            end
            for (int i = 0; i < exp_words.size() && base + i < wr_q.size();
                 i++) begin
                checks++;
                if (wr_q[base+i] !== {10'(i), exp_words[i]}) begin
                    failures++;
                    $display("FAIL rand_word%0d: got %h want %h",
                             i, wr_q[base+i], {10'(i), exp_words[i]});
                end
            end
        end
    endtask

    task automatic test_full_frame;
        int base;
        int s0;
        exp_words.delete();
        repeat (1024) exp_words.push_back(18'($urandom));
        base = wr_q.size();
        s0 = stall_cnt;
        do_frame(1'b0, 0);
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt - s0 != 1024) begin
            failures++;
            $display("FAIL full_stalls: got %0d want 1024", stall_cnt - s0);
        end
        checks++;
        if (wr_q.size() - base != 1024) begin
            failures++;
            $display("FAIL full_count: got %0d want 1024", wr_q.size() - base);
        end
        for (int i = 0; i < 1024 && base + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[base+i] !== {10'(i), exp_words[i]}) begin
                failures++;
                $display("FAIL full_word%0d: got %h want %h",
                         i, wr_q[base+i], {10'(i), exp_words[i]});
            end
        end
        checks++;
        if (wr_q.size() > 0 && wr_q[wr_q.size()-1][27:18] !== 10'h3FF) begin
            failures++;
            $display("FAIL full_last_addr: got %h want 3ff",
                     wr_q[wr_q.size()-1][27:18]);
        end
        checks++;
        if ({load_done, load_err} !== 2'b10) begin
            failures++;
            $display("FAIL full_done: done/err=%b want 10",
                     {load_done, load_err});
        end
    endtask

    task automatic test_async_reset;
        int base;
        logic [33:0] outs;
        exp_words.delete();
        repeat (6) exp_words.push_back(18'($urandom));
        build_frame(1'b0);
        base = wr_q.size();
        send_bytes(10, 0);
        checks++;
        if ({cpu_reset, load_busy} !== 2'b11) begin
            failures++;
            $display("FAIL mid_frame: rst/busy=%b want 11",
                     {cpu_reset, load_busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {rx_ready, mem_addr, mem_data, mem_we,
                cpu_reset, load_busy, load_done, load_err};
        checks++;
        if (outs !== 34'd0) begin
            failures++;
            $display("FAIL async_reset: got %h want 0", outs);
        end
        checks++;
        if (wr_q.size() - base != 2) begin
            failures++;
            $display("FAIL pre_reset_writes: got %0d want 2",
                     wr_q.size() - base);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_words.delete();
        exp_words.push_back(18'($urandom));
        base = wr_q.size();
        do_frame(1'b0, 0);
        @(posedge clk);
        #1;
        checks++;
        if ({load_done, load_err, cpu_reset} !== 3'b100 ||
            wr_q.size() - base != 1) begin
            failures++;
            $display("FAIL post_reset_frame: done/err/rst=%b writes=%0d want 100 1",
                     {load_done, load_err, cpu_reset}, wr_q.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_idle_discard();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_random_frames();
        test_full_frame();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
